// File: rtl/tlb_lookup_unit_if.sv
// Update, lookup and response signals between a TLB requester and tlb_lookup_unit.
interface tlb_lookup_unit_if #(
    parameter int IDX_BITS = 3
);
    logic                update_va_en;
    logic                update_pa_en;
    logic [IDX_BITS-1:0] update_index;
    logic [31:0]         update_value;
    logic                flush_en;
    logic                lookup_en;
    logic [31:0]         lookup_va;
    logic                stall;
    logic                rsp_valid;
    logic                rsp_hit;
    logic [31:0]         rsp_pa;
    logic                rsp_writable;

    modport master (
        output update_va_en, update_pa_en, update_index, update_value, flush_en,
        output lookup_en, lookup_va, stall,
        input  rsp_valid, rsp_hit, rsp_pa, rsp_writable
    );

    modport slave (
        input  update_va_en, update_pa_en, update_index, update_value, flush_en,
        input  lookup_en, lookup_va, stall,
        output rsp_valid, rsp_hit, rsp_pa, rsp_writable
    );
endinterface

// File: rtl/tlb_lookup_unit.sv
// Fully-associative TLB: VA/PA-half entry updates, flush, and a one-cycle registered lookup.
module tlb_lookup_unit #(
    parameter int NUM_ENTRIES = 8,
    parameter int IDX_BITS    = 3,
    parameter int PAGE_OFFSET = 12
) (
    input logic            clk,
    input logic            reset,
    tlb_lookup_unit_if.slave bus
);
    localparam int TAG_W = 32 - PAGE_OFFSET;

    logic [TAG_W-1:0]       vpn [NUM_ENTRIES];
    logic [TAG_W-1:0]       ppn [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] writable;
    logic [NUM_ENTRIES-1:0] valid;

    logic             hit;
    logic [TAG_W-1:0] hit_ppn;
    logic             hit_wr;

    // PA write follows VA write so its valid bit wins; flush is applied last so it beats both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                vpn[i] <= '0;
                ppn[i] <= '0;
            end
            writable <= '0;
            valid    <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                if (bus.update_va_en && bus.update_index == IDX_BITS'(i)) begin
                    vpn[i]   <= bus.update_value[31:PAGE_OFFSET];
                    valid[i] <= 1'b0;
                end
                if (bus.update_pa_en && bus.update_index == IDX_BITS'(i)) begin
                    ppn[i]      <= bus.update_value[31:PAGE_OFFSET];
                    writable[i] <= bus.update_value[1];
                    valid[i]    <= bus.update_value[0];
                end
            end
            if (bus.flush_en) begin
                valid <= '0;
            end
        end
    end

    // First match in ascending index order wins when software loads duplicate tags.
    always_comb begin
        hit     = 1'b0;
        hit_ppn = '0;
        hit_wr  = 1'b0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (!hit && valid[i] && vpn[i] == bus.lookup_va[31:PAGE_OFFSET]) begin
                hit     = 1'b1;
                hit_ppn = ppn[i];
                hit_wr  = writable[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rsp_valid    <= 1'b0;
            bus.rsp_hit      <= 1'b0;
            bus.rsp_pa       <= '0;
            bus.rsp_writable <= 1'b0;
        end else if (!bus.stall) begin
            bus.rsp_valid <= bus.lookup_en;
            if (bus.lookup_en) begin
                bus.rsp_hit      <= hit;
                bus.rsp_pa       <= hit ? {hit_ppn, bus.lookup_va[PAGE_OFFSET-1:0]} : bus.lookup_va;
                bus.rsp_writable <= hit_wr;
            end
        end
    end
endmodule

// File: tb/tb_tlb_lookup_unit.sv
// Randomized and directed checks of tlb_lookup_unit against an array-based translation model.
module tb_tlb_lookup_unit;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;

    tlb_lookup_unit_if #(.IDX_BITS(3)) bus ();

    tlb_lookup_unit #(
        .NUM_ENTRIES(8),
        .IDX_BITS(3),
        .PAGE_OFFSET(12)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a table of translations plus the expected response registers.
    logic [19:0] m_vpn [8];
    logic [19:0] m_ppn [8];
    logic        m_wr  [8];
    logic        m_val [8];
    logic        e_valid, e_hit, e_wr;
    logic [31:0] e_pa;

    function automatic logic [34:0] got();
        return {bus.rsp_valid, bus.rsp_hit, bus.rsp_pa, bus.rsp_writable};
    endfunction

    function automatic logic [34:0] expected();
        return {e_valid, e_hit, e_pa, e_wr};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_vpn[i] = '0; m_ppn[i] = '0; m_wr[i] = 1'b0; m_val[i] = 1'b0;
        end
        e_valid = 1'b0; e_hit = 1'b0; e_pa = '0; e_wr = 1'b0;
    endtask

    // Translate against the table as it stood before this cycle's updates, then apply updates.
    task automatic cycle();
        logic        found;
        logic [31:0] pa;
        logic        wr;
        found = 1'b0; pa = bus.lookup_va; wr = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (m_val[i] && m_vpn[i] == bus.lookup_va[31:12]) begin
                found = 1'b1;
                pa    = {m_ppn[i], bus.lookup_va[11:0]};
                wr    = m_wr[i];
            end
        end
        if (!bus.stall) begin
            e_valid = bus.lookup_en;
            if (bus.lookup_en) begin
                e_hit = found; e_pa = pa; e_wr = wr;
            end
        end
        if (bus.update_va_en) begin
            m_vpn[bus.update_index] = bus.update_value[31:12];
            m_val[bus.update_index] = 1'b0;
        end
        if (bus.update_pa_en) begin
            m_ppn[bus.update_index] = bus.update_value[31:12];
            m_wr[bus.update_index]  = bus.update_value[1];
            m_val[bus.update_index] = bus.update_value[0];
        end
        if (bus.flush_en) begin
            for (int i = 0; i < 8; i++) m_val[i] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic va_en, input logic pa_en, input logic [2:0] idx,
                         input logic [31:0] val, input logic flush, input logic lk,
                         input logic [31:0] lva, input logic stl);
        bus.update_va_en = va_en;
        bus.update_pa_en = pa_en;
        bus.update_index = idx;
        bus.update_value = val;
        bus.flush_en     = flush;
        bus.lookup_en    = lk;
        bus.lookup_va    = lva;
        bus.stall        = stl;
        cycle();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.update_va_en = 1'b0; bus.update_pa_en = 1'b0; bus.update_index = '0;
        bus.update_value = '0; bus.flush_en = 1'b0; bus.lookup_en = 1'b0;
        bus.lookup_va = '0; bus.stall = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (got() !== 35'h0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", got(), 35'h0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_miss_passthrough();
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 32'h00400123, 1'b0);
        vectors++;
        if (got() !== {1'b1, 1'b0, 32'h00400123, 1'b0}) begin
            errors++;
            $display("FAIL miss_passthrough: got %h want %h", got(), {1'b1, 1'b0, 32'h00400123, 1'b0});
        end
        idle();
        vectors++;
        if (got() !== {1'b0, 1'b0, 32'h00400123, 1'b0}) begin
            errors++;
            $display("FAIL idle_hold: got %h want %h", got(), {1'b0, 1'b0, 32'h00400123, 1'b0});
        end
    endtask

    task automatic test_basic_hit();
        drive(1'b1, 1'b0, 3'd2, 32'h00400000, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 3'd2, 32'h00812003, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 32'h00400abc, 1'b0);
        vectors++;
        if (got() !== {1'b1, 1'b1, 32'h00812abc, 1'b1}) begin
            errors++;
            $display("FAIL basic_hit: got %h want %h", got(), {1'b1, 1'b1, 32'h00812abc, 1'b1});
        end
    endtask

    task automatic test_va_rewrite();
        drive(1'b1, 1'b0, 3'd2, 32'h00500000, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 32'h00500010, 1'b0);
        vectors++;
        if (got() !== {1'b1, 1'b0, 32'h00500010, 1'b0}) begin
            errors++;
            $display("FAIL va_rewrite_new: got %h want %h", got(), {1'b1, 1'b0, 32'h00500010, 1'b0});
        end
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 32'h00400abc, 1'b0);
        vectors++;
        if (got() !== {1'b1, 1'b0, 32'h00400abc, 1'b0}) begin
            errors++;
            $display("FAIL va_rewrite_old: got %h want %h", got(), {1'b1, 1'b0, 32'h00400abc, 1'b0});
        end
    endtask

    task automatic test_multi_match();
        drive(1'b1, 1'b0, 3'd5, 32'h12345000, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 3'd5, 32'hbbbbb001, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 3'd1, 32'h12345000, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 3'd1, 32'haaaaa003, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b0);
        vectors++;
        if (got() !== {1'b1, 1'b1, 32'haaaaa678, 1'b1}) begin
            errors++;
            $display("FAIL multi_match: got %h want %h", got(), {1'b1, 1'b1, 32'haaaaa678, 1'b1});
        end
    endtask

    task automatic test_flush();
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b1, 32'h12345001, 1'b0);
        vectors++;
        if (got() !== {1'b1, 1'b1, 32'haaaaa001, 1'b1}) begin
            errors++;
            $display("FAIL flush_same_cycle: got %h want %h", got(), {1'b1, 1'b1, 32'haaaaa001, 1'b1});
        end
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 32'h12345001, 1'b0);
        vectors++;
        if (got() !== {1'b1, 1'b0, 32'h12345001, 1'b0}) begin
            errors++;
            $display("FAIL flush_after: got %h want %h", got(), {1'b1, 1'b0, 32'h12345001, 1'b0});
        end
    endtask

    task automatic test_same_cycle_write();
        drive(1'b1, 1'b1, 3'd6, 32'h77777001, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 32'h77777abc, 1'b0);
        vectors++;
        if (got() !== {1'b1, 1'b1, 32'h77777abc, 1'b0}) begin
            errors++;
            $display("FAIL va_pa_same_cycle: got %h want %h", got(), {1'b1, 1'b1, 32'h77777abc, 1'b0});
        end
        drive(1'b0, 1'b1, 3'd3, 32'h66666003, 1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 32'h77777abc, 1'b0);
        vectors++;
        if (got() !== {1'b1, 1'b0, 32'h77777abc, 1'b0}) begin
            errors++;
            $display("FAIL flush_beats_set: got %h want %h", got(), {1'b1, 1'b0, 32'h77777abc, 1'b0});
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 3'd4, 32'h0abcd000, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 3'd4, 32'h0fedc003, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 32'h0abcd111, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 32'h99999000 + 32'(i), 1'b1);
            vectors++;
            if (got() !== {1'b1, 1'b1, 32'h0fedc111, 1'b1}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %h want %h", i, got(), {1'b1, 1'b1, 32'h0fedc111, 1'b1});
            end
        end
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 32'h99999222, 1'b0);
        vectors++;
        if (got() !== {1'b1, 1'b0, 32'h99999222, 1'b0}) begin
            errors++;
            $display("FAIL stall_release: got %h want %h", got(), {1'b1, 1'b0, 32'h99999222, 1'b0});
        end
    endtask

    task automatic test_reset_midflight();
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 32'h0abcd222, 1'b0);
        vectors++;
        if (got() !== {1'b1, 1'b1, 32'h0fedc222, 1'b1}) begin
            errors++;
            $display("FAIL pre_reset_hit: got %h want %h", got(), {1'b1, 1'b1, 32'h0fedc222, 1'b1});
        end
        #2 reset = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (got() !== 35'h0) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", got(), 35'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 32'h0abcd222, 1'b0);
        vectors++;
        if (got() !== {1'b1, 1'b0, 32'h0abcd222, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_miss: got %h want %h", got(), {1'b1, 1'b0, 32'h0abcd222, 1'b0});
        end
    endtask

    task automatic test_random();
        logic [19:0] pool [4];
        pool[0] = 20'h00001; pool[1] = 20'h00002; pool[2] = 20'hfffff; pool[3] = 20'h80000;
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0,
                  3'($urandom_range(0, 7)),
                  {pool[$urandom_range(0, 3)] ^ 20'($urandom_range(0, 1) << $urandom_range(0, 19)),
                   10'($urandom), 2'($urandom)},
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 7,
                  {pool[$urandom_range(0, 3)], 12'($urandom)},
                  $urandom_range(0, 6) == 0);
            vectors++;
            if (got() !== expected()) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h", n, got(), expected());
            end
        end
    endtask

    initial begin
        test_reset();
        test_miss_passthrough();
        test_basic_hit();
        test_va_rewrite();
        test_multi_match();
        test_flush();
        test_same_cycle_write();
        test_stall();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
